// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler between register-file (A) and ALU-word (B) requesters, feeding the UART TX serializer.
// Optional Busy-rise watchdog: define TX_WATCHDOG_EN.
module uart_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int WD_CYCLES  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_A,
    input  logic [DATA_WIDTH-1:0]   DATA_A,
    output logic                    ACK_A,
    input  logic                    REQ_B,
    input  logic [2*DATA_WIDTH-1:0] DATA_B,
    output logic                    ACK_B,
    input  logic                    TX_BUSY,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VALID,
    output logic                    SCHED_BUSY,
    output logic                    TX_ERR
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t                  state;
    logic                    last_b;
    logic [1:0]              bytes_left;
    logic [2*DATA_WIDTH-1:0] hold;
    logic                    grant_a;
    logic                    grant_b;
    logic                    wd_abort;

    if (WD_CYCLES < 1) begin : g_bad_wd
        $error("WD_CYCLES must be at least 1");
    end

    always_comb begin
        grant_a = (state == IDLE) && REQ_A && (!REQ_B || last_b);
        grant_b = (state == IDLE) && REQ_B && !grant_a;
    end

    // The current byte always sits in the low lane of the hold register.
    assign TX_DATA  = hold[DATA_WIDTH-1:0];
    assign TX_VALID = (state == ISSUE) && !TX_BUSY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            last_b     <= 1'b1;
            bytes_left <= 2'd0;
            hold       <= '0;
            ACK_A      <= 1'b0;
            ACK_B      <= 1'b0;
            SCHED_BUSY <= 1'b0;
        end else begin
            ACK_A <= grant_a;
            ACK_B <= grant_b;
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        state      <= ISSUE;
                        SCHED_BUSY <= 1'b1;
                        last_b     <= grant_b;
                        hold       <= grant_b ? DATA_B : {{DATA_WIDTH{1'b0}}, DATA_A};
                        bytes_left <= grant_b ? 2'd2 : 2'd1;
                    end
                end
                ISSUE: begin
                    if (!TX_BUSY) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (TX_BUSY) begin
                        state <= WAIT_LO;
                    end else if (wd_abort) begin
                        state      <= IDLE;
                        SCHED_BUSY <= 1'b0;
                        bytes_left <= 2'd0;
                    end
                end
                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        bytes_left <= bytes_left - 2'd1;
                        if (bytes_left > 2'd1) begin
                            state <= ISSUE;
                            hold  <= {{DATA_WIDTH{1'b0}}, hold[2*DATA_WIDTH-1:DATA_WIDTH]};
                        end else begin
                            state      <= IDLE;
                            SCHED_BUSY <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TX_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Abort on the edge that would complete the WD_CYCLES-th idle WAIT_HI cycle.
    assign wd_abort = (state == WAIT_HI) && !TX_BUSY && (wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wd_cnt <= '0;
            TX_ERR <= 1'b0;
        end else begin
            TX_ERR <= wd_abort;
            if (state != WAIT_HI) begin
                wd_cnt <= '0;
            end else if (!TX_BUSY && !wd_abort) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign wd_abort = 1'b0;
    assign TX_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with an 11-cycle Busy serializer model.
module tb_uart_tx_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_A;
    logic [7:0]  DATA_A;
    logic        ACK_A;
    logic        REQ_B;
    logic [15:0] DATA_B;
    logic        ACK_B;
    logic        TX_BUSY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        SCHED_BUSY;
    logic        TX_ERR;

    int checks   = 0;
    int failures = 0;

    logic       model_en = 1'b1;
    int         busy_cnt = 0;
    logic [7:0] tx_q[$];
    int         n_ack_a = 0;
    int         n_ack_b = 0;
    int         n_err   = 0;
    int         n_viol  = 0;

    uart_tx_sched #(.DATA_WIDTH(8), .WD_CYCLES(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_A     (REQ_A),
        .DATA_A    (DATA_A),
        .ACK_A     (ACK_A),
        .REQ_B     (REQ_B),
        .DATA_B    (DATA_B),
        .ACK_B     (ACK_B),
        .TX_BUSY   (TX_BUSY),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .SCHED_BUSY(SCHED_BUSY),
        .TX_ERR    (TX_ERR)
    );

    always #5 CLK = ~CLK;

    // Serializer: Busy high for 11 cycles after each accepted valid pulse.
    always @(posedge CLK) begin
        if (model_en && TX_VALID) busy_cnt <= 11;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign TX_BUSY = (busy_cnt != 0);

    always @(negedge CLK) begin
        if (TX_VALID) begin
            tx_q.push_back(TX_DATA);
            if (TX_BUSY) n_viol++;
        end
        if (ACK_A) n_ack_a++;
        if (ACK_B) n_ack_b++;
        if (TX_ERR) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (TX_BUSY !== lvl && n < 100) begin
            step();
            n++;
        end
        if (TX_BUSY !== lvl) check(tag, {31'b0, TX_BUSY}, {31'b0, lvl});
    endtask

    task automatic clear_mon();
        tx_q.delete();
        n_ack_a = 0;
        n_ack_b = 0;
        n_err   = 0;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_outs"}, {24'b0, ACK_A, ACK_B, TX_VALID, SCHED_BUSY, TX_ERR, 3'b0},  32'h0);
        check({tag, "_txdata"}, {24'b0, TX_DATA}, 32'h0);
    endtask

    task automatic check_queue(input string tag, input logic [7:0] exp[$]);
        check({tag, "_count"}, tx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            logic [7:0] obs;
            obs = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), {24'b0, obs}, {24'b0, exp[i]});
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        step();
        step();
        RST = 1'b1;
        step();
    endtask

    initial begin
        RST    = 1'b0;
        REQ_A  = 1'b0;
        REQ_B  = 1'b0;
        DATA_A = 8'h00;
        DATA_B = 16'h0000;
        step();
        step();
        check_outs_zero("por");
        RST = 1'b1;
        step();
        clear_mon();

        // Single A transfer
        REQ_A  = 1'b1;
        DATA_A = 8'hA5;
        step();
        check("a_ack", {31'b0, ACK_A}, 32'd1);
        check("a_valid", {31'b0, TX_VALID}, 32'd1);
        check("a_data", {24'b0, TX_DATA}, 32'hA5);
        check("a_sbusy", {31'b0, SCHED_BUSY}, 32'd1);
        REQ_A = 1'b0;
        wait_busy(1'b1, "a_busy_rise");
        wait_busy(1'b0, "a_busy_fall");
        check("a_sbusy_at_fall", {31'b0, SCHED_BUSY}, 32'd1);
        step();
        check("a_sbusy_after", {31'b0, SCHED_BUSY}, 32'd0);
        check("a_ack_count", n_ack_a, 1);
        check_queue("a_q", '{8'hA5});
        clear_mon();

        // Two-byte B transfer, low byte first
        REQ_B  = 1'b1;
        DATA_B = 16'h1234;
        step();
        check("b_ack", {31'b0, ACK_B}, 32'd1);
        check("b_valid_lo", {31'b0, TX_VALID}, 32'd1);
        check("b_data_lo", {24'b0, TX_DATA}, 32'h34);
        REQ_B = 1'b0;
        wait_busy(1'b1, "b_busy_rise0");
        wait_busy(1'b0, "b_busy_fall0");
        check("b_gap_novalid", {31'b0, TX_VALID}, 32'd0);
        step();
        check("b_valid_hi", {31'b0, TX_VALID}, 32'd1);
        check("b_data_hi", {24'b0, TX_DATA}, 32'h12);
        check("b_no_reack", {31'b0, ACK_B}, 32'd0);
        wait_busy(1'b1, "b_busy_rise1");
        wait_busy(1'b0, "b_busy_fall1");
        step();
        check("b_sbusy_after", {31'b0, SCHED_BUSY}, 32'd0);
        check("b_ack_count", n_ack_b, 1);
        check_queue("b_q", '{8'h34, 8'h12});

        // Both requesters held from reset: A, B, A, B
        REQ_A  = 1'b1;
        REQ_B  = 1'b1;
        DATA_A = 8'h5A;
        DATA_B = 16'hBEEF;
        RST    = 1'b0;
        #1;
        step();
        clear_mon();
        RST = 1'b1;
        begin
            int n = 0;
            while (tx_q.size() < 6 && n < 200) begin
                step();
                n++;
            end
        end
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        begin
            int n = 0;
            while (SCHED_BUSY && n < 100) begin
                step();
                n++;
            end
        end
        check("rr_idle", {31'b0, SCHED_BUSY}, 32'd0);
        check("rr_ack_a", n_ack_a, 2);
        check("rr_ack_b", n_ack_b, 2);
        check_queue("rr_q", '{8'h5A, 8'hEF, 8'hBE, 8'h5A, 8'hEF, 8'hBE});
        clear_mon();

        // Serializer never raises Busy
        model_en = 1'b0;
        REQ_B    = 1'b1;
        DATA_B   = 16'hCAFE;
        step();
        check("wd_ack", {31'b0, ACK_B}, 32'd1);
        check("wd_data_lo", {24'b0, TX_DATA}, 32'hFE);
        REQ_B = 1'b0;
`ifdef TX_WATCHDOG_EN
        repeat (8) step();
        check("wd_err_early", {31'b0, TX_ERR}, 32'd0);
        check("wd_sbusy_early", {31'b0, SCHED_BUSY}, 32'd1);
        step();
        check("wd_err_pulse", {31'b0, TX_ERR}, 32'd1);
        check("wd_sbusy_idle", {31'b0, SCHED_BUSY}, 32'd0);
        step();
        check("wd_err_width", {31'b0, TX_ERR}, 32'd0);
        repeat (5) step();
        check("wd_err_count", n_err, 1);
`else
        repeat (20) step();
        check("wd_stuck_sbusy", {31'b0, SCHED_BUSY}, 32'd1);
        check("wd_no_err", {31'b0, TX_ERR}, 32'd0);
`endif
        check_queue("wd_q", '{8'hFE});
        model_en = 1'b1;
        RST = 1'b0;
        #1;
        check_outs_zero("mid_rst");
        step();
        RST = 1'b1;
        step();
        clear_mon();

        // Reset while B's low byte is in WAIT_LO
        REQ_B  = 1'b1;
        DATA_B = 16'h7788;
        step();
        check("rb_ack", {31'b0, ACK_B}, 32'd1);
        check("rb_data_lo", {24'b0, TX_DATA}, 32'h88);
        REQ_B = 1'b0;
        wait_busy(1'b1, "rb_busy_rise");
        step();
        RST = 1'b0;
        #1;
        check_outs_zero("rb_rst");
        step();
        step();
        RST = 1'b1;
        repeat (20) step();
        check("rb_idle", {31'b0, SCHED_BUSY}, 32'd0);
        check_queue("rb_q", '{8'h88});
        REQ_A  = 1'b1;
        DATA_A = 8'h3C;
        step();
        check("ra_ack", {31'b0, ACK_A}, 32'd1);
        check("ra_valid", {31'b0, TX_VALID}, 32'd1);
        check("ra_data", {24'b0, TX_DATA}, 32'h3C);
        check("ra_sbusy", {31'b0, SCHED_BUSY}, 32'd1);
        REQ_A = 1'b0;
        wait_busy(1'b1, "ra_busy_rise");
        wait_busy(1'b0, "ra_busy_fall");
        step();
        check("ra_sbusy_after", {31'b0, SCHED_BUSY}, 32'd0);
        check_queue("ra_q", '{8'h88, 8'h3C});
        check("ra_ack_b_count", n_ack_b, 1);

        check("valid_while_busy", n_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler in front of the UART TX serializer FSM. It arbitrates round-robin between a single-byte requester (A, register-file read data) and a two-byte requester (B, 16-bit ALU result). It issues each byte to the UART TX as a one-cycle valid pulse and tracks the serializer's Busy handshake so that no frame is overrun. It runs entirely in the UART TX clock domain.

## Interface
- DATA_WIDTH, 8, width of one UART byte (TX_DATA, DATA_A); DATA_B is 2*DATA_WIDTH.
- WD_CYCLES, 8, watchdog limit in cycles for TX_BUSY to rise after a valid pulse (used only with TX_WATCHDOG_EN).

- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- REQ_A  in  1  requester A has a byte; held with DATA_A until ACK_A.
- DATA_A  in  DATA_WIDTH  byte from A.
- ACK_A  out  1  one-cycle pulse: DATA_A captured.
- REQ_B  in  1  requester B has a word; held with DATA_B until ACK_B.
- DATA_B  in  2*DATA_WIDTH  word from B, sent low byte first.
- ACK_B  out  1  one-cycle pulse: DATA_B captured.
- TX_BUSY  in  1  Busy from the UART TX serializer.
- TX_DATA  out  DATA_WIDTH  byte presented to the serializer.
- TX_VALID  out  1  one-cycle pulse: serializer starts a frame with TX_DATA.
- SCHED_BUSY  out  1  high whenever state is not IDLE.
- TX_ERR  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE, no request: stay.
- IDLE, one request: grant it.
- IDLE, both requests: grant the side not granted last. The last-grant pointer resets to B, so A wins first.
- On grant: capture the data into the hold register, set bytes_left (A: 1, B: 2), set the ACK flag, and go to ISSUE.
- ISSUE, TX_BUSY=0: TX_VALID=1 and TX_DATA = current byte; go to WAIT_HI.
- ISSUE, TX_BUSY=1: TX_VALID=0; stay.
- ACK_A/ACK_B: high only in the first ISSUE cycle of a transaction, even if ISSUE stalls. Exactly one ACK per transaction.
- WAIT_HI: wait for TX_BUSY=1, then go to WAIT_LO.
- WAIT_LO: wait for TX_BUSY=0, then decrement bytes_left.
  - bytes_left nonzero: advance to the high byte and go to ISSUE.
  - Otherwise: go to IDLE.
- TX_DATA is held stable from ISSUE until the byte's WAIT_LO exit. In IDLE, TX_DATA holds its last value.
- Requests are not sampled outside IDLE. Requesters keep REQ asserted and are served in a later IDLE.
- Reset values: all outputs 0, state IDLE, pointer B, bytes_left 0, hold register 0, watchdog counter 0.
- Reset mid-transaction aborts immediately. Remaining bytes are dropped and no ACK or TX_VALID follows.

## Timing
- Grant latency: request sampled at IDLE edge n, with TX_BUSY=0. In cycle n+1: ACK, TX_VALID, TX_DATA and SCHED_BUSY are all high.
- TX_VALID is exactly 1 cycle wide. It is never asserted while TX_BUSY=1.
- Inter-byte gap for B: TX_BUSY=0 is sampled in WAIT_LO at edge k, and the high-byte TX_VALID is in cycle k+1.
- SCHED_BUSY falls in the cycle after the last byte's TX_BUSY=0 is sampled. The earliest next grant is sampled at that same IDLE edge.
- A requester sees ACK at an edge and must drop or update REQ by the next edge. The minimum transaction is 4 cycles, so no double grant occurs.

## Configuration
- TX_WATCHDOG_EN defined:
  - A counter runs in WAIT_HI and clears on entry.
  - If TX_BUSY has not risen after WD_CYCLES cycles in WAIT_HI: go to IDLE, pulse TX_ERR for 1 cycle, and drop the remaining bytes.
  - The pointer updates as for a normal grant.
- TX_WATCHDOG_EN undefined:
  - WAIT_HI waits indefinitely.
  - TX_ERR is tied to 0 and no counter is synthesized.

## Test plan
- Reset check: assert RST low mid-simulation -> all outputs 0 within the same cycle, SCHED_BUSY=0.
- Single A, DATA_A=0xA5; the serializer model holds TX_BUSY high for 11 cycles -> one ACK_A pulse, one TX_VALID with TX_DATA=0xA5, SCHED_BUSY low 1 cycle after TX_BUSY falls.
- B with DATA_B=0x1234 -> one ACK_B, then TX_VALID with 0x34, then TX_VALID with 0x12 one cycle after the first frame's TX_BUSY falls.
- REQ_A=1 and REQ_B=1 both held from reset -> grant order A, B, A, B. Check TX_DATA sequences and that no TX_VALID occurs while TX_BUSY=1.
- Watchdog (macro on, WD_CYCLES=8): TX_BUSY stuck 0 after a B request -> TX_ERR pulses 8 cycles into WAIT_HI, the high byte is never issued, state returns to IDLE. With the macro off, SCHED_BUSY stays 1 until reset.
- Reset asserted while B's first byte is in WAIT_LO -> no second TX_VALID. After release, a new A request is granted normally.
